// File: rtl/score_display_scanner_if.sv
// Score/scan bus between the game logic, the display scanner and the segment decoder.
interface score_display_scanner_if #(
  parameter int unsigned NDIGITS = 4
) ();
  logic                   inc;
  logic                   clr;
  logic [3:0]             bcd;
  logic                   blank;
  logic [NDIGITS-1:0]     digit_sel;
  logic [4*NDIGITS-1:0]   score_bcd;
  logic                   saturated;

  modport master (
    output inc, clr,
    input  bcd, blank, digit_sel, score_bcd, saturated
  );

  modport slave (
    input  inc, clr,
    output bcd, blank, digit_sel, score_bcd, saturated
  );
endinterface

// File: rtl/score_display_scanner.sv
// Saturating packed-BCD score counter multiplexed onto one shared 7-segment digit bus.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module score_display_scanner #(
  parameter int unsigned NDIGITS     = 4,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic                    clk,
  input  logic                    rst,
  score_display_scanner_if.slave  bus
);
  localparam int unsigned SCORE_W = 4 * NDIGITS;
  localparam int unsigned DIV_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W   = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIGITS - 1);

  logic [SCORE_W-1:0] score_q, score_d, score_inc;
  logic               sat_q, sat_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [3:0]         bcd_q, bcd_d;
  logic               blank_q, blank_d;
  logic [NDIGITS-1:0] sel_q, sel_d;
  logic               carry;
  logic               all_nines;

  // Ripple BCD +1 and all-9s detect
  always_comb begin
    score_inc = score_q;
    carry     = 1'b1;
    all_nines = 1'b1;
    for (int i = 0; i < int'(NDIGITS); i++) begin
      if (score_q[4*i +: 4] != 4'd9) all_nines = 1'b0;
      if (carry) begin
        if (score_q[4*i +: 4] == 4'd9) begin
          score_inc[4*i +: 4] = 4'd0;
        end else begin
          score_inc[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
  end

  always_comb begin
    score_d = score_q;
    sat_d   = sat_q;
    div_d   = div_q + DIV_W'(1);
    idx_d   = idx_q;
    bcd_d   = 4'd0;
    sel_d   = '1;
    blank_d = 1'b0;

    if (bus.clr) begin
      score_d = '0;
      sat_d   = 1'b0;
    end else if (bus.inc) begin
      if (all_nines) sat_d   = 1'b1;
      else           score_d = score_inc;
    end

    if (div_q == DIV_LAST) begin
      div_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end

    for (int i = 0; i < int'(NDIGITS); i++) begin
      if (IDX_W'(i) == idx_q) begin
        bcd_d    = score_q[4*i +: 4];
        sel_d[i] = 1'b0;
      end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Blank when this digit and every digit above it are zero; digit 0 always shows
    blank_d = (idx_q != '0);
    for (int i = 0; i < int'(NDIGITS); i++) begin
      if (IDX_W'(i) >= idx_q && score_q[4*i +: 4] != 4'd0) blank_d = 1'b0;
    end
`else
    blank_d = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      score_q <= '0;
      sat_q   <= 1'b0;
      div_q   <= '0;
      idx_q   <= '0;
      bcd_q   <= 4'd0;
      blank_q <= 1'b1;
      sel_q   <= '1;
    end else begin
      score_q <= score_d;
      sat_q   <= sat_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      bcd_q   <= bcd_d;
      blank_q <= blank_d;
      sel_q   <= sel_d;
    end
  end

  assign bus.score_bcd = score_q;
  assign bus.saturated = sat_q;
  assign bus.bcd       = bcd_q;
  assign bus.blank     = blank_q;
  assign bus.digit_sel = sel_q;
endmodule
